// File: rtl/cache_line_mem_if.sv
// Line-transfer engine: one 128-bit fill or write-back request becomes four
// classic Wishbone single transfers under one CYC, with ERR/timeout status.
module cache_line_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [127:0]          i_req_wdata,
  output logic                  o_resp_valid,
  output logic                  o_resp_err,
  output logic [127:0]          o_resp_rdata,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [3:0]            o_wb_sel,
  output logic [31:0]           o_wb_dat,
  input  logic [31:0]           i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-5:0] r_line;
  logic [127:0]          r_wdata;
  logic [127:0]          r_rdata;
  logic [1:0]            r_beat;
  logic [TW-1:0]         r_tcnt;
  logic                  r_ready;
  logic                  r_cyc;
  logic                  r_resp_valid;
  logic                  r_resp_err;

  // Bus outputs are gated by CYC so the interface reads all-zero outside a transfer.
  assign o_req_ready  = r_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_rdata;
  assign o_wb_cyc     = r_cyc;
  assign o_wb_stb     = r_cyc;
  assign o_wb_we      = r_cyc & r_we;
  assign o_wb_sel     = {4{r_cyc}};
  assign o_wb_adr     = r_cyc ? {r_line, r_beat, 2'b00} : '0;
  assign o_wb_dat     = r_cyc ? r_wdata[{r_beat, 5'd0} +: 32] : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_line       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_beat       <= 2'd0;
      r_tcnt       <= '0;
      r_ready      <= 1'b1;
      r_cyc        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_line  <= i_req_addr[ADDR_WIDTH-1:4];
            r_wdata <= i_req_wdata;
            r_beat  <= 2'd0;
            r_tcnt  <= '0;
            r_ready <= 1'b0;
            r_cyc   <= 1'b1;
            r_state <= S_XFER;
          end
        end
        // ERR takes priority over a simultaneous ACK; the beat's data is not stored.
        S_XFER: begin
          if (i_wb_err) begin
            r_cyc        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else if (i_wb_ack) begin
            if (!r_we) begin
              r_rdata[{r_beat, 5'd0} +: 32] <= i_wb_dat;
            end
            r_tcnt <= '0;
            if (r_beat == 2'd3) begin
              r_cyc        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end else if (TIMEOUT != 0) begin
            if (r_tcnt == TW'(TIMEOUT - 1)) begin
              r_cyc        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_mem_if.sv
// Directed bench for cache_line_mem_if: a timeout-8 instance plus a
// timeout-disabled instance sharing the same stimulus.
module tb_cache_line_mem_if;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqWe = 1'b0;
  logic [31:0]  reqAddr = '0;
  logic [127:0] reqWdata = '0;
  logic [31:0]  wbDatI = '0;
  logic         wbAck = 1'b0;
  logic         wbErr = 1'b0;

  logic         reqReady, respValid, respErr, wbCyc, wbStb, wbWe;
  logic [127:0] respRdata;
  logic [31:0]  wbAdr, wbDatO;
  logic [3:0]   wbSel;

  logic         d0Ready, d0RespValid, d0RespErr, d0Cyc, d0Stb, d0We;
  logic [127:0] d0Rdata;
  logic [31:0]  d0Adr, d0DatO;
  logic [3:0]   d0Sel;

  int checks = 0;
  int failures = 0;

  logic [31:0]  recAdr [4];
  logic [31:0]  recDat [4];
  logic         recWe  [4];
  int           respCycle;
  int           cycHigh;
  logic         recRespErr;
  logic [127:0] recRdata;
  logic         readyAtResp;

  always #5 clk = ~clk;

  cache_line_mem_if #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_we(reqWe),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_resp_valid(respValid), .o_resp_err(respErr), .o_resp_rdata(respRdata),
    .o_wb_cyc(wbCyc), .o_wb_stb(wbStb), .o_wb_we(wbWe), .o_wb_adr(wbAdr),
    .o_wb_sel(wbSel), .o_wb_dat(wbDatO), .i_wb_dat(wbDatI),
    .i_wb_ack(wbAck), .i_wb_err(wbErr)
  );

  cache_line_mem_if #(.ADDR_WIDTH(32), .TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(d0Ready), .i_req_we(reqWe),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_resp_valid(d0RespValid), .o_resp_err(d0RespErr), .o_resp_rdata(d0Rdata),
    .o_wb_cyc(d0Cyc), .o_wb_stb(d0Stb), .o_wb_we(d0We), .o_wb_adr(d0Adr),
    .o_wb_sel(d0Sel), .o_wb_dat(d0DatO), .i_wb_dat(wbDatI),
    .i_wb_ack(wbAck), .i_wb_err(wbErr)
  );

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0; reqValid = 1'b0; wbAck = 1'b0; wbErr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Drives one request and plays the Wishbone slave from the bench side,
  // recording what the engine presented on each beat.
  task automatic runXfer(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                         input int waits, input int errBeat, input bit bothOnErr,
                         input bit noAck, input logic [31:0] rdBase, input bit holdValid);
    int b = 0;
    int waitCnt = 0;
    bit newBeat = 1'b1;
    cycHigh = 0; respCycle = -1; recRespErr = 1'b0; recRdata = '0; readyAtResp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recAdr[i] = 32'hDEAD_BEEF; recDat[i] = 32'hDEAD_BEEF; recWe[i] = 1'bx;
    end
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (!holdValid) reqValid = 1'b0;
      wbAck = 1'b0; wbErr = 1'b0;
      if (respValid) begin
        respCycle = cyc; recRespErr = respErr; recRdata = respRdata; readyAtResp = reqReady;
        break;
      end
      if (wbStb) begin
        cycHigh++;
        if (newBeat && b < 4) begin
          recAdr[b] = wbAdr; recDat[b] = wbDatO; recWe[b] = wbWe;
        end
        newBeat = 1'b0;
        if (!noAck) begin
          if (waitCnt < waits) begin
            waitCnt++;
          end else begin
            if (b == errBeat) begin
              wbErr = 1'b1; wbAck = bothOnErr;
            end else begin
              wbAck = 1'b1;
            end
            wbDatI = rdBase + 32'(b);
            b++; waitCnt = 0; newBeat = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++;
    if (reqReady !== 1'b1 || wbCyc !== 1'b0 || wbStb !== 1'b0 || respValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: ready=%b cyc=%b stb=%b resp=%b, required 1 0 0 0",
               reqReady, wbCyc, wbStb, respValid);
    end
    checks++;
    if (respRdata !== 128'd0 || wbAdr !== 32'd0 || wbSel !== 4'd0 || respErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_data: rdata=%h adr=%h sel=%h err=%b, required zeros",
               respRdata, wbAdr, wbSel, respErr);
    end
    doReset();
    checks++;
    if (reqReady !== 1'b1 || wbCyc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: ready=%b cyc=%b, required 1 0", reqReady, wbCyc);
    end
  endtask

  task automatic test_fill();
    logic [31:0] expAdr [4];
    expAdr = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    runXfer(1'b0, 32'h0000_1234, '0, 0, -1, 1'b0, 1'b0, 32'hA0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (recAdr[i] !== expAdr[i] || recWe[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fill_adr%0d: adr=%h we=%b, required %h 0", i, recAdr[i], recWe[i], expAdr[i]);
      end
    end
    checks++;
    if (respCycle !== 5 || recRespErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_resp: cycle=%0d err=%b, required 5 0", respCycle, recRespErr);
    end
    checks++;
    if (recRdata !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      failures++;
      $display("[TB] FAIL fill_rdata: got %h, required 000000a3000000a2000000a1000000a0", recRdata);
    end
  endtask

  task automatic test_writeback();
    logic [31:0] expDat [4];
    expDat = '{32'h11, 32'h22, 32'h33, 32'h44};
    runXfer(1'b1, 32'h0000_0040, {32'h44, 32'h33, 32'h22, 32'h11}, 2, -1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (recDat[i] !== expDat[i] || recWe[i] !== 1'b1 || recAdr[i] !== 32'h40 + 32'(4 * i)) begin
        failures++;
        $display("[TB] FAIL wb_beat%0d: dat=%h we=%b adr=%h, required %h 1 %h",
                 i, recDat[i], recWe[i], recAdr[i], expDat[i], 32'h40 + 32'(4 * i));
      end
    end
    checks++;
    if (cycHigh !== 12 || respCycle !== 13 || recRespErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wb_timing: cyc_high=%0d resp_cycle=%0d err=%b, required 12 13 0",
               cycHigh, respCycle, recRespErr);
    end
    checks++;
    if (recRdata !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      failures++;
      $display("[TB] FAIL wb_rdata_kept: got %h, required previous fill line", recRdata);
    end
  endtask

  task automatic test_err();
    runXfer(1'b0, 32'h0000_0200, '0, 0, 2, 1'b0, 1'b0, 32'hB0, 1'b0);
    checks++;
    if (cycHigh !== 3 || respCycle !== 4 || recRespErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_resp: cyc_high=%0d resp_cycle=%0d err=%b, required 3 4 1",
               cycHigh, respCycle, recRespErr);
    end
    checks++;
    if (recRdata !== 128'h000000A3_000000A2_000000B1_000000B0) begin
      failures++;
      $display("[TB] FAIL err_rdata: got %h, required 000000a3000000a2000000b1000000b0", recRdata);
    end
  endtask

  task automatic test_timeout();
    bit d0Bad = 1'b0;
    runXfer(1'b0, 32'h0000_0800, '0, 0, -1, 1'b0, 1'b1, 32'h0, 1'b0);
    checks++;
    if (cycHigh !== 8 || respCycle !== 9 || recRespErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_8: cyc_high=%0d resp_cycle=%0d err=%b, required 8 9 1",
               cycHigh, respCycle, recRespErr);
    end
    for (int i = 0; i < 30; i++) begin
      if (d0RespValid !== 1'b0 || d0Cyc !== 1'b1) d0Bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (d0Bad) begin
      failures++;
      $display("[TB] FAIL timeout_0: disabled-timeout instance left XFER (cyc=%b resp=%b), required hold",
               d0Cyc, d0RespValid);
    end
    doReset();
    runXfer(1'b0, 32'h0000_0900, '0, 7, -1, 1'b0, 1'b0, 32'hD0, 1'b0);
    checks++;
    if (cycHigh !== 32 || respCycle !== 33 || recRespErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_edge: cyc_high=%0d resp_cycle=%0d err=%b, required 32 33 0",
               cycHigh, respCycle, recRespErr);
    end
  endtask

  task automatic test_reset_mid();
    bit sawBus = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h0000_0300;
    @(negedge clk);
    reqValid = 1'b0; wbAck = 1'b1; wbDatI = 32'hE0;
    @(negedge clk);
    wbAck = 1'b0;
    checks++;
    if (wbStb !== 1'b1 || wbAdr !== 32'h304) begin
      failures++;
      $display("[TB] FAIL rst_mid_pre: stb=%b adr=%h, required 1 00000304", wbStb, wbAdr);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (wbCyc !== 1'b0 || wbStb !== 1'b0 || reqReady !== 1'b1 || respValid !== 1'b0 ||
        wbAdr !== 32'd0 || respRdata !== 128'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid: cyc=%b stb=%b ready=%b resp=%b adr=%h rdata=%h, required 0 0 1 0 0 0",
               wbCyc, wbStb, reqReady, respValid, wbAdr, respRdata);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (respValid !== 1'b0 || wbCyc !== 1'b0) sawBus = 1'b1;
    end
    checks++;
    if (sawBus) begin
      failures++;
      $display("[TB] FAIL rst_mid_after: activity after reset, required none");
    end
  endtask

  task automatic test_back_to_back();
    runXfer(1'b0, 32'h0000_0500, '0, 0, 0, 1'b1, 1'b0, 32'hC0, 1'b1);
    checks++;
    if (respCycle !== 2 || recRespErr !== 1'b1 || recRdata[31:0] !== 32'd0) begin
      failures++;
      $display("[TB] FAIL ack_err_both: cycle=%0d err=%b word0=%h, required 2 1 00000000",
               respCycle, recRespErr, recRdata[31:0]);
    end
    checks++;
    if (readyAtResp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_in_resp: ready=%b, required 0", readyAtResp);
    end
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1 || wbCyc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_resp: ready=%b cyc=%b, required 1 0", reqReady, wbCyc);
    end
    @(negedge clk);
    reqValid = 1'b0;
    checks++;
    if (wbCyc !== 1'b1 || wbAdr !== 32'h500 || reqReady !== 1'b0) begin
      failures++;
      $display("[TB] FAIL second_accept: cyc=%b adr=%h ready=%b, required 1 00000500 0",
               wbCyc, wbAdr, reqReady);
    end
    doReset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback();
    test_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
